mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM pipeline register driven by the execute stage: ALU result, store data, destination register, M and WB control bits, and the zero flag.
- Performs word loads and stores over a req/ack data-memory bus that may insert wait states, stalling the pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register and produces the writeback/forwarding data path (write_data_reg, rd_WB, wb_WB) that feeds back into execute.

Parameters:
- ADDR_W, 32, width of dmem_addr (low bits of res_ex).
- MEM_TIMEOUT, 255, number of WAIT cycles without ack before a bus error is declared; legal range 1..65535.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- res_ex  in  32  ALU result from EX/MEM; byte address for loads/stores
- write_data_ex  in  32  store data from EX/MEM
- write_register_ex  in  5  destination register from EX/MEM
- m_MEM  in  3  {branch, mem_read, mem_write}
- wb_MEM  in  2  {reg_write, mem_to_reg}
- zero  in  1  ALU zero flag from EX/MEM
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid when dmem_ack = 1
- dmem_ack  in  1  access complete (single-cycle pulse)
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB
- pcsrc  out  1  branch taken = m_MEM[2] & zero
- read_data_wb  out  32  MEM/WB load data
- alu_res_wb  out  32  MEM/WB ALU result
- rd_WB  out  5  MEM/WB destination register
- wb_WB  out  2  MEM/WB {reg_write, mem_to_reg}; bit 1 feeds the EX forwarding unit
- write_data_reg  out  32  wb_WB[0] ? read_data_wb : alu_res_wb (combinational)
- align_err  out  1  combinational: access requested with res_ex[1:0] != 0
- bus_err  out  1  sticky timeout flag

Behaviour:
- access = (m_MEM[1] | m_MEM[0]) & (res_ex[1:0] == 0). If both m_MEM[1] and m_MEM[0] are set, the access is a store.
- dmem_addr = res_ex[ADDR_W-1:0]; dmem_wdata = write_data_ex; dmem_we = m_MEM[0]. All three are held stable while dmem_req is high; EX/MEM is frozen by stall_mem.
- FSM states:
  - IDLE: dmem_req = access.
    - access & dmem_ack: zero-wait completion; stay in IDLE, stall_mem = 0.
    - access & !dmem_ack: go to WAIT, stall_mem = 1, counter cleared.
  - WAIT: dmem_req = 1; counter increments each cycle without ack.
    - dmem_ack: go to IDLE, stall_mem = 0 in the ack cycle, so MEM/WB and the pipeline advance on that edge.
    - Counter reaches MEM_TIMEOUT without ack: go to ERR.
  - ERR: one cycle. dmem_req = 0, stall_mem = 0, bus_err set. The instruction retires as a bubble (wb_WB loads 00). Next state is IDLE.
- stall_mem = (IDLE & access & !dmem_ack) | (WAIT & !dmem_ack & counter != MEM_TIMEOUT).
- MEM/WB register, updated on each rising edge when stall_mem = 0:
  - read_data_wb <= dmem_rdata if this is a load completing, else unchanged.
  - alu_res_wb <= res_ex; rd_WB <= write_register_ex; wb_WB <= wb_MEM.
- While stall_mem = 1, MEM/WB HOLDS its contents (no bubble). This keeps WB forwarding valid for the instruction frozen in EX.
- Misaligned access (align_err = 1): no bus request; MEM/WB loads wb_WB = 00, alu_res_wb = res_ex, rd_WB = write_register_ex. No stall.
- Non-memory instruction: pass-through with one cycle of latency, no stall.
- pcsrc is purely combinational; it is not gated by stall.
- Reset, applied synchronously on a clk edge with rst = 1:
  - State IDLE, counter 0, bus_err 0.
  - read_data_wb, alu_res_wb, rd_WB and wb_WB all 0.
  - While rst = 1, dmem_req = 0 and stall_mem = 0. A WAIT in progress is abandoned; a late ack after reset is ignored.
- bus_err clears only on rst.

Test Plan:
- R-type: res_ex = 0x0000_0005, wb_MEM = 10, rd = 8, m_MEM = 000 -> next cycle alu_res_wb = 5, rd_WB = 8, wb_WB = 10, write_data_reg = 5; dmem_req never asserted.
- Zero-wait load: m_MEM = 010, res_ex = 0x100, wb_MEM = 11, ack in the same cycle with rdata = 0xDEADBEEF -> stall_mem stays 0; next cycle read_data_wb = 0xDEADBEEF, write_data_reg = 0xDEADBEEF.
- 3-wait store then load: m_MEM = 001, addr 0x40, data 0x1234; ack on the 4th request cycle -> stall_mem high for 3 cycles; dmem_addr/wdata/we stable throughout; MEM/WB unchanged during the stall; one write observed. The following load of 0x40 completes normally.
- Misaligned load at res_ex = 0x102 -> align_err = 1, dmem_req = 0, no stall; next cycle wb_WB = 00.
- Timeout with MEM_TIMEOUT = 4 and no ack -> stall for 4 WAIT cycles, then ERR; bus_err = 1 and sticky; wb_WB = 00; dmem_req drops in the ERR cycle.
- Reset in the 2nd WAIT cycle -> after the edge: dmem_req = 0, stall_mem = 0, wb_WB = 00, bus_err = 0; a subsequent stray ack has no effect.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline: drives a req/ack data bus with wait states
// and timeout, and owns the MEM/WB pipeline register feeding writeback and forwarding.
module mem_stage #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       res_ex,
   input  logic [31:0]       write_data_ex,
   input  logic [4:0]        write_register_ex,
   input  logic [2:0]        m_MEM,
   input  logic [1:0]        wb_MEM,
   input  logic              zero,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              stall_mem,
   output logic              pcsrc,
   output logic [31:0]       read_data_wb,
   output logic [31:0]       alu_res_wb,
   output logic [4:0]        rd_WB,
   output logic [1:0]        wb_WB,
   output logic [31:0]       write_data_reg,
   output logic              align_err,
   output logic              bus_err
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StErr  = 2'd2;

   localparam logic [15:0] Timeout = 16'(MEM_TIMEOUT);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        bus_err_q;
   logic [31:0] read_data_q, alu_res_q;
   logic [4:0]  rd_q;
   logic [1:0]  wb_q;

   logic mem_op, access, ld_done, req, stall, bubble;

   assign mem_op    = m_MEM[1] | m_MEM[0];
   assign access    = mem_op & (res_ex[1:0] == 2'b00);
   assign align_err = mem_op & (res_ex[1:0] != 2'b00);
   assign pcsrc     = m_MEM[2] & zero;

   assign dmem_addr  = res_ex[ADDR_W-1:0];
   assign dmem_wdata = write_data_ex;
   assign dmem_we    = m_MEM[0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req     = 1'b0;
      stall   = 1'b0;
      ld_done = 1'b0;
      case (state_q)
         StIdle: begin
            req = access;
            if (access) begin
               if (dmem_ack) begin
                  ld_done = ~m_MEM[0];
               end else begin
                  stall   = 1'b1;
                  state_d = StWait;
                  cnt_d   = '0;
               end
            end
         end
         StWait: begin
            req = 1'b1;
            if (dmem_ack) begin
               ld_done = ~m_MEM[0];
               state_d = StIdle;
            end else begin
               stall = (cnt_q != Timeout);
               cnt_d = cnt_q + 16'd1;
               // Last stalled WAIT cycle; ERR then lets the instruction retire as a bubble.
               if (cnt_q >= Timeout - 16'd1) begin
                  state_d = StErr;
               end
            end
         end
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign dmem_req  = req & ~rst;
   assign stall_mem = stall & ~rst;
   assign bubble    = align_err | (state_q == StErr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bus_err_q   <= 1'b0;
         read_data_q <= '0;
         alu_res_q   <= '0;
         rd_q        <= '0;
         wb_q        <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_d == StErr) begin
            bus_err_q <= 1'b1;
         end
         // MEM/WB holds during a stall so WB forwarding stays valid for the frozen EX instruction.
         if (!stall) begin
            alu_res_q <= res_ex;
            rd_q      <= write_register_ex;
            wb_q      <= bubble ? 2'b00 : wb_MEM;
            if (ld_done) begin
               read_data_q <= dmem_rdata;
            end
         end
      end
   end

   assign read_data_wb   = read_data_q;
   assign alu_res_wb     = alu_res_q;
   assign rd_WB          = rd_q;
   assign wb_WB          = wb_q;
   assign bus_err        = bus_err_q;
   assign write_data_reg = wb_q[0] ? read_data_q : alu_res_q;

endmodule
